// File: rtl/gca_pkg.sv
// rtl/gca_pkg.sv - shared types and helpers for the GCA line sequencer
package gca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2
  } line_state_t;

  localparam int X_LSB  = 0;
  localparam int X_W    = 11;
  localparam int Y_LSB  = 11;
  localparam int Y_W    = 10;
  localparam int ADDR_W = 21;
  localparam int CNT_W  = 12;

  // Framebuffer address is {y, x} taken straight from a packed coordinate word.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [31:0] coord);
    return {coord[Y_LSB +: Y_W], coord[X_LSB +: X_W]};
  endfunction

endpackage

// File: rtl/gca_line_ctrl.sv
// rtl/gca_line_ctrl.sv - line command sequencer: loads the stepper, walks it one pixel per
// accepted framebuffer write, reports done/error/pixel count
module gca_line_ctrl
  import gca_pkg::*;
#(
  parameter int COLOR_W   = 16,
  parameter int LD_CYCLES = 3,
  parameter int MAX_PIX   = 2048
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_c0,
  input  logic [31:0]        cmd_c1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               abort,
  output logic [31:0]        ln_c0,
  output logic [31:0]        ln_c1,
  output logic               ln_ld,
  output logic               ln_step,
  input  logic               ln_fc,
  input  logic [ADDR_W-1:0]  ln_addr,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   pix_cnt
);

  localparam int                LDW     = $clog2(LD_CYCLES + 1);
  localparam logic [LDW-1:0]    LD_LAST = LDW'(LD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GUARD   = CNT_W'(MAX_PIX - 1);

  line_state_t        state_q, state_d;
  logic [LDW-1:0]     ld_cnt_q;
  logic               abort_pend_q;
  logic [31:0]        c0_q, c1_q;
  logic [COLOR_W-1:0] color_q;
  logic               ld_q, done_q, err_q;
  logic [CNT_W-1:0]   pix_cnt_q;

  logic hs, abort_eff, at_guard, finish, guard_hit;

  always_comb begin
    state_d   = state_q;
    finish    = 1'b0;
    hs        = (state_q == DRAW) && wr_ready;
    abort_eff = abort || abort_pend_q;
    at_guard  = (pix_cnt_q == GUARD);
    guard_hit = hs && !ln_fc && !abort_eff && at_guard;
    ln_step   = hs && !ln_fc && !abort_eff && !at_guard;
    case (state_q)
      IDLE: if (cmd_valid) state_d = LOAD;
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          finish  = 1'b1;
        end else if (ld_cnt_q == LD_LAST) begin
          state_d = DRAW;
        end
      end
      DRAW: begin
        // A pending abort or the pixel guard only terminate on a handshake, so the
        // presented pixel is always written before the line ends.
        if (hs && (ln_fc || abort_eff || at_guard)) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ld_cnt_q     <= '0;
      abort_pend_q <= 1'b0;
      c0_q         <= '0;
      c1_q         <= '0;
      color_q      <= '0;
      ld_q         <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pix_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= finish;
      ld_q         <= (state_d == LOAD);
      abort_pend_q <= (state_q == DRAW) && (state_d == DRAW) && abort_eff;
      if (state_q == LOAD) ld_cnt_q <= ld_cnt_q + 1'b1;
      else                 ld_cnt_q <= '0;
      if (state_q == IDLE && cmd_valid) begin
        c0_q      <= cmd_c0;
        c1_q      <= cmd_c1;
        color_q   <= cmd_color;
        pix_cnt_q <= '0;
        err_q     <= 1'b0;
      end else begin
        if (hs && pix_cnt_q != '1) pix_cnt_q <= pix_cnt_q + 1'b1;
        if (guard_hit) err_q <= 1'b1;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wr_valid  = (state_q == DRAW);
  assign wr_addr   = ln_addr;
  assign wr_data   = color_q;
  assign ln_c0     = c0_q;
  assign ln_c1     = c1_q;
  assign ln_ld     = ld_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pix_cnt   = pix_cnt_q;

endmodule
